wb_initiator: RTL and testbench

WB_INITIATOR -- requirements
Module: wb_initiator

---
 rtl/wb_initiator_if.sv | 50 +++++
 rtl/wb_initiator.sv | 130 +++++++++++++
 tb/tb_wb_initiator.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/wb_initiator_if.sv
// wb_initiator_if: groups the command, response and Wishbone classic
// initiator signals of wb_initiator into one bundle.
//   master : the wb_initiator side. It consumes commands, produces responses
//            and drives the Wishbone bus.
//   slave  : the environment side. It offers commands, consumes responses
//            and plays the Wishbone target.
// Signal groups:
//   cmd_*  : valid/ready command channel (we, addr, wdata, sel)
//   rsp_*  : valid/ready response channel (rdata, err)
//   wbm_*  : Wishbone classic initiator (cyc, stb, we, sel, adr, dat, ack)
interface wb_initiator_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_we;
  logic [31:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_sel;

  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic        wbm_cyc_o;
  logic        wbm_stb_o;
  logic        wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_adr_o;
  logic [31:0] wbm_dat_o;
  logic [31:0] wbm_dat_i;
  logic        wbm_ack_i;

  modport master (
    input  cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    output cmd_ready,
    output rsp_valid, rsp_rdata, rsp_err,
    input  rsp_ready,
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_dat_i, wbm_ack_i
  );

  modport slave (
    output cmd_valid, cmd_we, cmd_addr, cmd_wdata, cmd_sel,
    input  cmd_ready,
    input  rsp_valid, rsp_rdata, rsp_err,
    output rsp_ready,
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_dat_i, wbm_ack_i
  );
endinterface

// File: rtl/wb_initiator.sv
// wb_initiator: converts one valid/ready command into a single Wishbone
// classic cycle and returns the result on a valid/ready response channel.
// Only one transaction is outstanding at a time.
// A cycle that sees no ack within TIMEOUT bus cycles is aborted. The abort
// returns rsp_err = 1 and rsp_rdata = 0.
// Parameters:
//   TIMEOUT : the maximum number of bus cycles waited for ack (1..65535)
// Ports:
//   clock   : the single clock. All logic uses the rising edge.
//   reset_n : the asynchronous active-low reset. The integrator releases it
//             synchronously to clock.
//   bus     : the command, response and Wishbone signals (master modport)
module wb_initiator #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic           clock,
  input  logic           reset_n,
  wb_initiator_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    BUS,
    RESP
  } state_t;

  // The counter holds the bus cycles already waited. It reaches TIMEOUT on
  // the same edge that ends the TIMEOUT-th cycle, so the abort is taken
  // when the count is TIMEOUT-1 and ack is still low.
  localparam logic [15:0] LAST_WAIT = 16'(TIMEOUT - 1);

  state_t      state_q;
  state_t      state_d;
  logic [15:0] wait_cnt_q;

  logic        accept;
  logic        acked;
  logic        timed_out;

  logic        we_q;
  logic [3:0]  sel_q;
  logic [31:0] adr_q;
  logic [31:0] dat_q;
  logic [31:0] rdata_q;
  logic        err_q;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    acked     = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cmd_valid) begin
          accept  = 1'b1;
          state_d = BUS;
        end
      end
      BUS: begin
        // ack has priority over a timeout on the same edge.
        if (bus.wbm_ack_i) begin
          acked   = 1'b1;
          state_d = RESP;
        end else if (wait_cnt_q == LAST_WAIT) begin
          timed_out = 1'b1;
          state_d   = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wait_cnt_q <= '0;
      we_q       <= 1'b0;
      sel_q      <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      if (accept) begin
        wait_cnt_q <= '0;
        we_q       <= bus.cmd_we;
        sel_q      <= bus.cmd_sel;
        adr_q      <= bus.cmd_addr;
        dat_q      <= bus.cmd_wdata;
      end else if (state_q == BUS && !bus.wbm_ack_i) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end

      if (acked) begin
        rdata_q <= we_q ? '0 : bus.wbm_dat_i;
        err_q   <= 1'b0;
      end else if (timed_out) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

  // The handshake and strobe outputs come straight from the state register.
  // This way reset drops cyc/stb at once, and the two can never differ.
  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wbm_cyc_o = (state_q == BUS);
  assign bus.wbm_stb_o = (state_q == BUS);
  assign bus.rsp_valid = (state_q == RESP);

  assign bus.wbm_we_o  = we_q;
  assign bus.wbm_sel_o = sel_q;
  assign bus.wbm_adr_o = adr_q;
  assign bus.wbm_dat_o = dat_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_wb_initiator.sv
// tb_wb_initiator: table-driven bench for wb_initiator.
// It uses two instances: one with TIMEOUT=4 and one with TIMEOUT=2. The
// bench drives one shared set of stimulus signals. The command and ack
// inputs are steered to the selected instance only, so the other instance
// stays in IDLE. The outputs of the selected instance are muxed back for
// checking.
module tb_wb_initiator;

  typedef struct {
    bit          use2;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  sel;
    int unsigned ack_at;     // BUS cycle carrying ack; 0 = never
    logic [31:0] dat_in;
    int unsigned bp;         // cycles rsp_ready is held low
    int unsigned exp_cycles;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  logic        clock = 1'b0;
  logic        reset_n = 1'b1;
  logic        use2 = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_we = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_sel = '0;
  logic        rsp_ready = 1'b0;
  logic [31:0] wbm_dat_i = '0;
  logic        wbm_ack_i = 1'b0;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  rsp_t        sb_q[$];
  vec_t        vt[8];

  always #5 clock = ~clock;

  wb_initiator_if bus4();
  wb_initiator_if bus2();

  assign bus4.cmd_valid = cmd_valid & ~use2;
  assign bus2.cmd_valid = cmd_valid & use2;
  assign bus4.cmd_we    = cmd_we;
  assign bus2.cmd_we    = cmd_we;
  assign bus4.cmd_addr  = cmd_addr;
  assign bus2.cmd_addr  = cmd_addr;
  assign bus4.cmd_wdata = cmd_wdata;
  assign bus2.cmd_wdata = cmd_wdata;
  assign bus4.cmd_sel   = cmd_sel;
  assign bus2.cmd_sel   = cmd_sel;
  assign bus4.rsp_ready = rsp_ready & ~use2;
  assign bus2.rsp_ready = rsp_ready & use2;
  assign bus4.wbm_dat_i = wbm_dat_i;
  assign bus2.wbm_dat_i = wbm_dat_i;
  assign bus4.wbm_ack_i = wbm_ack_i & ~use2;
  assign bus2.wbm_ack_i = wbm_ack_i & use2;

  wb_initiator #(.TIMEOUT(4)) u_dut4 (.clock(clock), .reset_n(reset_n), .bus(bus4));
  wb_initiator #(.TIMEOUT(2)) u_dut2 (.clock(clock), .reset_n(reset_n), .bus(bus2));

  logic        o_cmd_ready, o_rsp_valid, o_rsp_err, o_cyc, o_stb, o_we;
  logic [3:0]  o_sel;
  logic [31:0] o_adr, o_dat, o_rdata;

  assign o_cmd_ready = use2 ? bus2.cmd_ready : bus4.cmd_ready;
  assign o_rsp_valid = use2 ? bus2.rsp_valid : bus4.rsp_valid;
  assign o_rsp_err   = use2 ? bus2.rsp_err   : bus4.rsp_err;
  assign o_rdata     = use2 ? bus2.rsp_rdata : bus4.rsp_rdata;
  assign o_cyc       = use2 ? bus2.wbm_cyc_o : bus4.wbm_cyc_o;
  assign o_stb       = use2 ? bus2.wbm_stb_o : bus4.wbm_stb_o;
  assign o_we        = use2 ? bus2.wbm_we_o  : bus4.wbm_we_o;
  assign o_sel       = use2 ? bus2.wbm_sel_o : bus4.wbm_sel_o;
  assign o_adr       = use2 ? bus2.wbm_adr_o : bus4.wbm_adr_o;
  assign o_dat       = use2 ? bus2.wbm_dat_o : bus4.wbm_dat_o;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic vec_t mkv(input bit u2, input logic we, input logic [31:0] addr,
                               input logic [31:0] wdata, input logic [3:0] sel,
                               input int unsigned ack_at, input logic [31:0] dat_in,
                               input int unsigned bp, input int unsigned cyc,
                               input logic [31:0] rdata, input logic err);
    vec_t v;
    v.use2 = u2; v.we = we; v.addr = addr; v.wdata = wdata; v.sel = sel;
    v.ack_at = ack_at; v.dat_in = dat_in; v.bp = bp;
    v.exp_cycles = cyc; v.exp_rdata = rdata; v.exp_err = err;
    return v;
  endfunction

  // Issues one command, plays the target, and then consumes the response.
  task automatic apply(input vec_t v);
    int unsigned n;
    rsp_t        exp_r;
    use2 = v.use2;
    chk("idle_cmd_ready", 32'(o_cmd_ready), 32'd1);
    cmd_valid = 1'b1;
    cmd_we    = v.we;
    cmd_addr  = v.addr;
    cmd_wdata = v.wdata;
    cmd_sel   = v.sel;
    exp_r.rdata = v.exp_rdata;
    exp_r.err   = v.exp_err;
    sb_q.push_back(exp_r);
    step();
    // Scramble the command inputs. The bus outputs must keep the captured values.
    cmd_valid = 1'b0;
    cmd_addr  = ~v.addr;
    cmd_wdata = $urandom;
    cmd_sel   = ~v.sel;
    cmd_we    = ~v.we;
    n = 0;
    while (o_cyc === 1'b1 && n < 20) begin
      n++;
      chk("bus_stb", 32'(o_stb), 32'd1);
      chk("bus_we", 32'(o_we), 32'(v.we));
      chk("bus_sel", 32'(o_sel), 32'(v.sel));
      chk("bus_adr", o_adr, v.addr);
      chk("bus_dat", o_dat, v.wdata);
      chk("bus_cmd_ready", 32'(o_cmd_ready), 32'd0);
      chk("bus_rsp_valid", 32'(o_rsp_valid), 32'd0);
      wbm_ack_i = (n == v.ack_at);
      wbm_dat_i = wbm_ack_i ? v.dat_in : $urandom;
      step();
    end
    wbm_ack_i = 1'b0;
    chk("bus_cycles", n, v.exp_cycles);
    for (int i = 0; i < int'(v.bp); i++) begin
      chk("bp_rsp_valid", 32'(o_rsp_valid), 32'd1);
      chk("bp_rdata", o_rdata, v.exp_rdata);
      chk("bp_err", 32'(o_rsp_err), 32'(v.exp_err));
      chk("bp_cmd_ready", 32'(o_cmd_ready), 32'd0);
      chk("bp_cyc", 32'(o_cyc), 32'd0);
      cmd_valid = 1'b1;
      cmd_addr  = 32'hBAD0_0000 | 32'(i);
      wbm_ack_i = 1'(i % 2);
      wbm_dat_i = $urandom;
      step();
    end
    cmd_valid = 1'b0;
    wbm_ack_i = 1'b0;
    chk("rsp_valid", 32'(o_rsp_valid), 32'd1);
    if (sb_q.size() == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL sb_pop: actual=empty required=entry");
    end else begin
      exp_r = sb_q.pop_front();
      chk("rsp_rdata", o_rdata, exp_r.rdata);
      chk("rsp_err", 32'(o_rsp_err), 32'(exp_r.err));
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    chk("post_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("post_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("post_cyc", 32'(o_cyc), 32'd0);
    chk("post_adr_held", o_adr, v.addr);
  endtask

  initial begin
    //         u2  we    addr          wdata         sel   ack bus_dat       bp cyc rdata         err
    vt[0] = mkv(0, 1'b1, 32'h3000_0004, 32'hDEAD_BEEF, 4'hF, 3, 32'h5555_AAAA, 0, 3, 32'h0000_0000, 1'b0);
    vt[1] = mkv(0, 1'b0, 32'h1000_0000, 32'h0000_0000, 4'hF, 1, 32'h1234_5678, 0, 1, 32'h1234_5678, 1'b0);
    vt[2] = mkv(0, 1'b0, 32'h4000_0008, 32'h0BAD_F00D, 4'hF, 0, 32'h0,         0, 4, 32'h0000_0000, 1'b1);
    vt[3] = mkv(1, 1'b0, 32'h5000_0010, 32'h0,         4'hF, 2, 32'hA5A5_0F0F, 0, 2, 32'hA5A5_0F0F, 1'b0);
    vt[4] = mkv(0, 1'b1, 32'h6000_0020, 32'h0102_0304, 4'h3, 4, 32'hFFFF_FFFF, 0, 4, 32'h0000_0000, 1'b0);
    vt[5] = mkv(0, 1'b0, 32'h7000_0040, 32'h0,         4'hF, 2, 32'hCAFE_F00D, 5, 2, 32'hCAFE_F00D, 1'b0);
    vt[6] = mkv(1, 1'b1, 32'h8000_0080, 32'h1111_2222, 4'hC, 0, 32'h0,         0, 2, 32'h0000_0000, 1'b1);
    vt[7] = mkv(0, 1'b0, 32'h9000_0100, 32'h0,         4'h8, 3, 32'h0000_00FF, 1, 3, 32'h0000_00FF, 1'b0);

    // The reset is asynchronous, so its values must appear before any clock edge.
    #2 reset_n = 1'b0;
    #1;
    chk("rst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    chk("rst_cyc", 32'(o_cyc), 32'd0);
    chk("rst_stb", 32'(o_stb), 32'd0);
    chk("rst_we", 32'(o_we), 32'd0);
    chk("rst_sel", 32'(o_sel), 32'd0);
    chk("rst_adr", o_adr, 32'd0);
    chk("rst_dat", o_dat, 32'd0);
    chk("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("rst_rdata", o_rdata, 32'd0);
    chk("rst_err", 32'(o_rsp_err), 32'd0);
    repeat (2) @(posedge clock);
    @(negedge clock) reset_n = 1'b1;
    step();

    for (int k = 0; k < 8; k++) begin
      apply(vt[k]);
    end

    // Reset pulse during BUS: the cycle is aborted and no response is produced.
    use2      = 1'b0;
    cmd_valid = 1'b1;
    cmd_we    = 1'b0;
    cmd_addr  = 32'h2000_0010;
    cmd_sel   = 4'hF;
    step();
    cmd_valid = 1'b0;
    step();
    chk("midrst_pre_cyc", 32'(o_cyc), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_cyc", 32'(o_cyc), 32'd0);
    chk("midrst_stb", 32'(o_stb), 32'd0);
    chk("midrst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    chk("midrst_adr", o_adr, 32'd0);
    step();
    chk("midrst_hold_rsp_valid", 32'(o_rsp_valid), 32'd0);
    @(negedge clock) reset_n = 1'b1;
    step();
    chk("midrst_cmd_ready", 32'(o_cmd_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("midrst_no_rsp", 32'(o_rsp_valid), 32'd0);
      chk("midrst_no_cyc", 32'(o_cyc), 32'd0);
      step();
    end
    apply(vt[1]);

    chk("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
